spi_shift_param: RTL and testbench

//  Parametrised SPI shift engine; next generation of the core 32-bit SPI shifter.

---
 rtl/spi_shift_param_if.sv | 37 +++
 rtl/spi_shift_param.sv | 128 ++++++++++++
 tb/tb_spi_shift_param.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_param_if.sv
// Bus bundle between the SPI register file / clock generator and the shift engine.
// The master side drives the controls and strobes; the slave side is the shift engine.
interface spi_shift_param_if #(
  parameter int MAX_CHAR = 64,
  parameter int BUS_W    = 32
);
  logic [MAX_CHAR/BUS_W-1:0]     latch;
  logic [BUS_W/8-1:0]            byte_sel;
  logic [$clog2(MAX_CHAR)-1:0]   len;
  logic                          lsb;
  logic                          go;
  logic                          abort;
  logic                          pos_edge;
  logic                          neg_edge;
  logic                          rx_negedge;
  logic                          tx_negedge;
  logic                          s_clk;
  logic                          s_in;
  logic [BUS_W-1:0]              p_in;
  logic                          tip;
  logic                          last;
  logic                          done;
  logic                          s_out;
  logic [MAX_CHAR-1:0]           p_out;

  modport master (
    output latch, byte_sel, len, lsb, go, abort, pos_edge, neg_edge,
           rx_negedge, tx_negedge, s_clk, s_in, p_in,
    input  tip, last, done, s_out, p_out
  );

  modport slave (
    input  latch, byte_sel, len, lsb, go, abort, pos_edge, neg_edge,
           rx_negedge, tx_negedge, s_clk, s_in, p_in,
    output tip, last, done, s_out, p_out
  );
endinterface

// File: rtl/spi_shift_param.sv
// Parametrised SPI shift engine: one character register loaded in bus words, shifted
// out MSB/LSB first while s_in is sampled back into the same register.
module spi_shift_param #(
  parameter int MAX_CHAR = 64,
  parameter int BUS_W    = 32
) (
  input logic              clk_shift,
  input logic              rst,
  spi_shift_param_if.slave bus
);

  localparam int NWORDS   = MAX_CHAR / BUS_W;
  localparam int LEN_BITS = $clog2(MAX_CHAR);
  localparam int CW       = LEN_BITS + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state;
  state_t              state_next;
  logic                done_q;
  logic                done_next;
  logic                s_out_q;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       len_full;
  logic [CW-1:0]       tx_pos;
  logic [CW-1:0]       rx_pos;
  logic [MAX_CHAR-1:0] data;
  logic [MAX_CHAR-1:0] data_next;
  logic                tip;
  logic                last;
  logic                tx_clk;
  logic                rx_clk;
  int                  sel_word;

  // A zero length field selects a full MAX_CHAR character via the extra top bit.
  assign len_full = {bus.len == '0, bus.len};
  assign tip      = (state == XFER);
  assign last     = (cnt == '0);
  assign tx_pos   = bus.lsb ? (len_full - cnt) : (cnt - ONE);
  assign rx_pos   = bus.lsb ? (len_full - (bus.rx_negedge ? (cnt + ONE) : cnt))
                            : (bus.rx_negedge ? cnt : (cnt - ONE));
  assign tx_clk   = (bus.tx_negedge ? bus.neg_edge : bus.pos_edge) & ~last;
  assign rx_clk   = (bus.rx_negedge ? bus.neg_edge : bus.pos_edge) & (~last | bus.s_clk);

  assign bus.tip   = tip;
  assign bus.last  = last;
  assign bus.done  = done_q;
  assign bus.s_out = s_out_q;
  assign bus.p_out = data;

  always_ff @(posedge clk_shift) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

  // Abort outranks normal completion, so an aborted transfer never reports done.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.go) state_next = XFER;
      end
      XFER: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (last && bus.pos_edge) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_shift) begin
    if (rst) begin
      cnt <= '0;
    end else if (!tip) begin
      cnt <= len_full;
    end else if (bus.pos_edge) begin
      cnt <= cnt - ONE;
    end
  end

  // While idle s_out keeps tracking the first bit so the line is primed before go.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      s_out_q <= 1'b0;
    end else if (tx_clk || !tip) begin
      s_out_q <= data[tx_pos[LEN_BITS-1:0]];
    end
  end

  always_comb begin
    data_next = data;
    sel_word  = 0;
    for (int k = NWORDS - 1; k >= 0; k--) begin
      if (bus.latch[k]) sel_word = k;
    end
    if ((|bus.latch) && !tip) begin
      for (int k = 0; k < NWORDS; k++) begin
        for (int b = 0; b < BUS_W / 8; b++) begin
          if ((k == sel_word) && bus.byte_sel[b]) begin
            data_next[k*BUS_W + 8*b +: 8] = bus.p_in[8*b +: 8];
          end
        end
      end
    end else if (rx_clk) begin
      data_next[rx_pos[LEN_BITS-1:0]] = bus.s_in;
    end
  end

  always_ff @(posedge clk_shift) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= data_next;
    end
  end

endmodule

// File: tb/tb_spi_shift_param.sv
// Scoreboard bench for spi_shift_param: stimulus pushes expected line bits and final
// characters; a monitor pops them as the engine shifts and signals done.
module tb_spi_shift_param;

  localparam int MC = 64;
  localparam int BW = 32;
  localparam int LB = 6;

  logic clk = 1'b0;
  logic rst;

  spi_shift_param_if #(.MAX_CHAR(MC), .BUS_W(BW)) bus ();

  spi_shift_param #(.MAX_CHAR(MC), .BUS_W(BW)) dut (
    .clk_shift (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [MC-1:0] model;
  bit            sout_q[$];
  logic [MC-1:0] pout_q[$];
  int            total = 0;
  int            bad = 0;
  int            done_seen = 0;

  task automatic checkOutput(input string name, input logic [MC-1:0] act, input logic [MC-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input int k, input logic [31:0] w, input logic [3:0] bs);
    bus.latch    = '0;
    bus.latch[k] = 1'b1;
    bus.byte_sel = bs;
    bus.p_in     = w;
    tick();
    bus.latch = '0;
    for (int b = 0; b < 4; b++) begin
      if (bs[b]) model[k*BW + 8*b +: 8] = w[8*b +: 8];
    end
  endtask

  // Monitor: checks s_out after every transmit strobe and p_out on every done pulse.
  initial begin
    bit pend;
    bit prev_done;
    pend = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (sout_q.size() > 0) begin
          bit e;
          e = sout_q.pop_front();
          checkOutput("s_out_bit", MC'(bus.s_out), MC'(e));
        end
      end
      if (!rst && bus.tip && (bus.tx_negedge ? bus.neg_edge : bus.pos_edge)) pend = 1'b1;
      if (bus.done) begin
        done_seen++;
        checkOutput("done_width", MC'(prev_done), MC'(0));
        if (pout_q.size() > 0) checkOutput("p_out_done", bus.p_out, pout_q.pop_front());
        else checkOutput("unexpected_done", MC'(bus.done), MC'(0));
      end
      prev_done = bus.done;
    end
  end

  // ld: 0 random load, 1 latch word 0 together with go, 2 keep data.
  // src: 0 loopback, 1 random s_in, 2 zero s_in. act: 0 none, 1 abort, 2 reset, 3 latch mid.
  task automatic applyStimulus(input int len, input bit lsb, input bit txn, input int src,
                               input int ld, input int act, input int act_at);
    int            n;
    int            seq[$];
    bit            r[$];
    logic [MC-1:0] exp;
    logic [31:0]   w;
    int            pos_cnt;
    int            rxi;
    int            d0;
    bit            fell;
    pos_cnt = 0;
    rxi = 0;
    fell = 1'b0;
    w = '0;
    n = (len == 0) ? MC : len;
    bus.len        = len[LB-1:0];
    bus.lsb        = lsb;
    bus.tx_negedge = txn;
    bus.rx_negedge = !txn;
    if (ld == 0) begin
      loadWord(0, $urandom, 4'hF);
      loadWord(1, $urandom, 4'hF);
    end
    tick();
    tick();
    if (ld == 1) begin
      w = $urandom;
      model[31:0] = w;
    end
    for (int i = 0; i < n; i++) seq.push_back(lsb ? i : n - 1 - i);
    for (int i = 0; i < n; i++) begin
      if (src == 0) r.push_back(model[seq[i]]);
      else if (src == 1) r.push_back(bit'($urandom_range(0, 1)));
      else r.push_back(1'b0);
    end
    exp = model;
    for (int i = 0; i < n; i++) exp[seq[i]] = r[i];
    for (int i = (txn ? 1 : 0); i < n; i++) sout_q.push_back(model[seq[i]]);
    if (txn) checkOutput("s_out_preload", MC'(bus.s_out), MC'(model[seq[0]]));
    if (act == 0 || act == 3) pout_q.push_back(exp);
    if (ld == 1) begin
      bus.latch    = 2'b01;
      bus.byte_sel = 4'hF;
      bus.p_in     = w;
    end
    bus.go = 1'b1;
    tick();
    bus.go    = 1'b0;
    bus.latch = '0;
    checkOutput("tip_rise", MC'(bus.tip), MC'(1));
    d0 = done_seen;
    for (int k = 0; k < 2*MC + 8; k++) begin
      if (txn) bus.s_in = (src == 0) ? bus.s_out : ((rxi < n) ? r[rxi] : 1'b0);
      bus.s_clk    = 1'b0;
      bus.pos_edge = 1'b1;
      tick();
      bus.pos_edge = 1'b0;
      bus.s_clk    = 1'b1;
      pos_cnt++;
      if (txn) rxi++;
      if (!bus.tip) begin
        fell = 1'b1;
        break;
      end
      tick();
      if (act != 0 && pos_cnt == act_at) begin
        if (act == 1) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          checkOutput("abort_tip", MC'(bus.tip), MC'(0));
          checkOutput("abort_done", MC'(bus.done), MC'(0));
          sout_q.delete();
          tick();
          checkOutput("abort_last", MC'(bus.last), MC'(0));
          checkOutput("abort_data", bus.p_out, model);
          tick();
          checkOutput("abort_no_done", MC'(done_seen - d0), MC'(0));
          break;
        end else if (act == 2) begin
          rst = 1'b1;
          tick();
          checkOutput("rst_tip", MC'(bus.tip), MC'(0));
          checkOutput("rst_s_out", MC'(bus.s_out), MC'(0));
          checkOutput("rst_p_out", bus.p_out, MC'(0));
          checkOutput("rst_done", MC'(bus.done), MC'(0));
          checkOutput("rst_last", MC'(bus.last), MC'(1));
          rst = 1'b0;
          sout_q.delete();
          model = '0;
          break;
        end else begin
          bus.latch    = 2'b11;
          bus.byte_sel = 4'hF;
          bus.p_in     = $urandom;
          tick();
          bus.latch = '0;
        end
      end
      if (!txn) bus.s_in = (src == 0) ? bus.s_out : ((rxi < n) ? r[rxi] : 1'b0);
      bus.neg_edge = 1'b1;
      tick();
      bus.neg_edge = 1'b0;
      bus.s_clk    = 1'b0;
      if (!txn) rxi++;
      tick();
    end
    bus.s_clk = 1'b0;
    if (act == 0 || act == 3) begin
      if (!fell) checkOutput("tip_timeout", MC'(bus.tip), MC'(0));
      tick();
      tick();
      checkOutput("done_count", MC'(done_seen - d0), MC'(1));
      model = exp;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.latch = '0;      bus.byte_sel = '0;   bus.len = '0;       bus.lsb = 1'b0;
    bus.go = 1'b0;       bus.abort = 1'b0;    bus.pos_edge = 1'b0; bus.neg_edge = 1'b0;
    bus.rx_negedge = 1'b1; bus.tx_negedge = 1'b0; bus.s_clk = 1'b0; bus.s_in = 1'b0;
    bus.p_in = '0;
    model = '0;
    tick();
    tick();
    checkOutput("reset_tip", MC'(bus.tip), MC'(0));
    checkOutput("reset_done", MC'(bus.done), MC'(0));
    checkOutput("reset_s_out", MC'(bus.s_out), MC'(0));
    checkOutput("reset_p_out", bus.p_out, MC'(0));
    checkOutput("reset_last", MC'(bus.last), MC'(1));
    rst = 1'b0;
    tick();

    bus.latch    = 2'b11;
    bus.byte_sel = 4'b0101;
    bus.p_in     = 32'hFFFF_FFFF;
    tick();
    bus.latch = '0;
    checkOutput("byte_lanes", bus.p_out, 64'h0000_0000_00FF_00FF);
    model = 64'h0000_0000_00FF_00FF;

    loadWord(0, 32'hA5A5_0F0F, 4'hF);
    loadWord(1, 32'h1234_5678, 4'hF);
    checkOutput("load_words", bus.p_out, 64'h1234_5678_A5A5_0F0F);

    $display("[TB] full 64-bit MSB-first loopback");
    applyStimulus(0, 1'b0, 1'b0, 0, 2, 0, 0);

    $display("[TB] 8-bit LSB-first with zero input");
    loadWord(0, 32'h0000_0081, 4'h1);
    applyStimulus(8, 1'b1, 1'b0, 2, 2, 0, 0);

    $display("[TB] abort then restart");
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 1, 5);
    applyStimulus(0, 1'b0, 1'b0, 0, 2, 0, 0);

    $display("[TB] latch during transfer and latch with go");
    applyStimulus(16, 1'b1, 1'b1, 1, 0, 3, 3);
    applyStimulus(12, 1'b0, 1'b0, 1, 1, 0, 0);

    $display("[TB] random transfers");
    for (int t = 0; t < 10; t++) begin
      bit tx;
      tx = bit'($urandom_range(0, 1));
      applyStimulus(int'($urandom_range(0, MC - 1)), bit'($urandom_range(0, 1)), tx,
                    int'($urandom_range(0, 1)), tx ? 0 : int'($urandom_range(0, 1)), 0, 0);
    end

    $display("[TB] reset during transfer");
    applyStimulus(0, 1'b1, 1'b0, 0, 0, 2, 7);

    tick();
    checkOutput("sout_q_empty", MC'(sout_q.size()), MC'(0));
    checkOutput("pout_q_empty", MC'(pout_q.size()), MC'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
